uart_rx_apb_if: RTL
===================

Name: uart_rx_apb_if

Overview:
- APB slave that sits directly downstream of the UART receiver.
- Drives the receiver's start request (rxStart) and captures each completed 11-bit frame when the receiver pulses store.
- Checks each frame for start, stop and parity errors, then buffers data and error flags in a 4-entry FIFO.
- Clears the start request on clrRxStartBit, and exposes control, data and status registers to the CPU.

Parameters:
- FIFO_DEPTH, 4, number of buffered frames; power of two, 2..16.
- CNT_W, 3, width of the occupancy count; must hold FIFO_DEPTH.

Ports:
- clk  input  1  system clock; everything is sampled on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable; marks the access phase.
- pwrite  input  1  APB write (1) or read (0).
- paddr  input  4  byte address; bits [1:0] are ignored.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data; valid in the access phase.
- pready  output  1  tied to 1 (zero wait states).
- pslverr  output  1  error response; valid in the access phase.
- rxData  input  11  frame from the receiver: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
- store  input  1  frame-complete indication from the receiver; may be held high for more than 1 cycle.
- clrRxStartBit  input  1  1-cycle request from the receiver to clear rxStart.
- rxStart  output  1  start-receiving enable to the receiver.
- irq  output  1  level interrupt.

Behaviour:
- Reset values while rst=0:
  - rxStart=0, irq=0, prdata=0, pslverr=0.
  - FIFO empty: pointers 0, count 0.
  - All CSRs 0, store edge-detect register 0.
- Access rule: a write or read takes effect only in the cycle where psel=1 and penable=1.
- CTRL at 0x0 (read/write):
  - [0] RX_EN drives rxStart directly.
  - [1] AUTO_REARM.
  - [2] ODD: 0 selects even parity, 1 selects odd.
  - [3] IE, interrupt enable.
- RX_EN update priority:
  - A CPU write to CTRL in the same cycle as clrRxStartBit wins (the CPU value is taken).
  - Else, if clrRxStartBit=1 and AUTO_REARM=0, RX_EN goes to 0.
  - Else, if clrRxStartBit=1 and AUTO_REARM=1, RX_EN stays 1.
- DATA at 0x4 (read-only):
  - A read in the access phase returns the FIFO head as {22'b0, FE, PE, data[7:0]} and pops it in that same cycle.
  - A read when the FIFO is empty returns 0 with pslverr=1; nothing is popped.
  - Writes to DATA are ignored, with pslverr=0.
- STATUS at 0x8:
  - [0] NE, FIFO not empty.
  - [1] FULL.
  - [2] OVR, sticky overrun; writing 1 to bit 2 clears it.
  - [3+CNT_W-1:3] COUNT, current occupancy.
  - All other bits read as 0 and ignore writes.
- Address 0xC reads as 0; paddr bits [3:2] fully decode 4 words, so there are no unmapped addresses.
- Capture:
  - A push request occurs on the rising edge of store only (store=1 while the registered store was 0), giving exactly 1 push per frame.
  - Pushed entry: data = rxData[8:1].
  - PE = ^rxData[9:1] XOR ODD; even parity passes when the XOR of data and parity is 0.
  - FE = (rxData[0]!=0) OR (rxData[10]!=1).
  - The entry is written on the cycle the edge is detected; NE rises on the next cycle.
- FIFO boundaries:
  - Push while full with no pop in the same cycle: the frame is dropped, OVR is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, COUNT stays FIFO_DEPTH, OVR is not set.
  - Push and pop in the same cycle while not empty: COUNT is unchanged.
  - Push while empty with a DATA read in the same cycle: the read still sees empty (pslverr=1), and the push lands.
  - Pointers wrap modulo FIFO_DEPTH.
- Interrupt: irq = IE & (NE | OVR), registered, so it asserts 1 cycle after the condition holds.
- Reset mid-operation: all state clears immediately, including rxStart, which forces the receiver out of pending starts.

Test Plan:
- Reset, then write CTRL=0x1 -> rxStart=1; read STATUS -> 0x0.
- With ODD=0, rxData=11'b1_0_01010101_0 and store held high 3 cycles -> COUNT=1; DATA read returns 0x055 (PE=0, FE=0); NE goes to 0.
- rxData=11'b0_1_10101010_1 (bad start, bad stop, parity 1 over 0xAA, ODD=0) -> DATA read returns 0x3AA (PE=1, FE=1).
- Push 5 frames 0x01..0x05 with no reads -> FULL=1, OVR=1, COUNT=4; reads return 0x01..0x04, then a 5th read gives pslverr=1 and prdata=0; writing STATUS=0x4 clears OVR.
- With the FIFO full, a store rising edge coincides with a DATA read -> head popped, new frame accepted, OVR stays 0, COUNT=4.
- Pulse clrRxStartBit with AUTO_REARM=0 -> rxStart=0 next cycle. With AUTO_REARM=1 -> rxStart stays 1. With a simultaneous CTRL write of 0x1 -> rxStart=1.

Source files
------------

// File: rtl/uart_rx_apb_if.sv
// APB slave for the UART receiver. It drives the receiver's start enable, checks each
// captured frame for start, stop and parity errors, and buffers the results in a small FIFO.
module uart_rx_apb_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [10:0] rxData,
    input  logic        store,
    input  logic        clrRxStartBit,
    output logic        rxStart,
    output logic        irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // CTRL bit positions
    localparam int RX_EN_BIT  = 0;
    localparam int REARM_BIT  = 1;
    localparam int ODD_BIT    = 2;
    localparam int IE_BIT     = 3;

    logic [3:0]       ctrl_reg, ctrl_next;
    logic             ovr_reg, ovr_next;
    logic             store_d_reg;
    logic             irq_reg, irq_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [9:0]       mem_reg [FIFO_DEPTH];

    logic             access;
    logic             wr_access;
    logic             rd_access;
    logic [1:0]       word_addr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             overrun;
    logic             frame_pe;
    logic             frame_fe;
    logic [9:0]       entry;
    logic [FIFO_DEPTH-1:0] wr_en;
    logic [31:0]      status_word;

    // Gating with rst keeps the bus outputs at 0 while reset is held.
    assign access     = psel & penable & rst;
    assign wr_access  = access & pwrite;
    assign rd_access  = access & ~pwrite;
    assign word_addr  = paddr[3:2];

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_CNT);

    assign push_req   = store & ~store_d_reg;
    assign pop        = rd_access & (word_addr == ADDR_DATA) & ~fifo_empty;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign overrun    = push_req & fifo_full & ~pop;

    assign frame_pe   = (^rxData[9:1]) ^ ctrl_reg[ODD_BIT];
    assign frame_fe   = rxData[0] | ~rxData[10];
    assign entry      = {frame_fe, frame_pe, rxData[8:1]};

    assign status_word = {{(29 - CNT_W){1'b0}}, count_reg, ovr_reg, fifo_full, ~fifo_empty};

    assign pready  = 1'b1;
    assign rxStart = ctrl_reg[RX_EN_BIT];
    assign irq     = irq_reg;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok & (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (rd_access) begin
            case (word_addr)
                ADDR_CTRL:   prdata = {28'b0, ctrl_reg};
                ADDR_DATA: begin
                    if (fifo_empty) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata = {22'b0, mem_reg[rd_ptr_reg]};
                    end
                end
                ADDR_STATUS: prdata = status_word;
                default:     prdata = '0;
            endcase
        end
    end

    // A CPU write to CTRL takes precedence over the receiver's clear request.
    always_comb begin
        ctrl_next = ctrl_reg;
        if (wr_access && (word_addr == ADDR_CTRL)) begin
            ctrl_next = pwdata[3:0];
        end else if (clrRxStartBit && !ctrl_reg[REARM_BIT]) begin
            ctrl_next[RX_EN_BIT] = 1'b0;
        end
    end

    // A new overrun in the same cycle as a clear keeps the flag set so the event is not lost.
    always_comb begin
        ovr_next = ovr_reg;
        if (wr_access && (word_addr == ADDR_STATUS) && pwdata[2]) begin
            ovr_next = 1'b0;
        end
        if (overrun) begin
            ovr_next = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        irq_next = ctrl_reg[IE_BIT] & (~fifo_empty | ovr_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg    <= '0;
            ovr_reg     <= 1'b0;
            store_d_reg <= 1'b0;
            irq_reg     <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            ctrl_reg    <= ctrl_next;
            ovr_reg     <= ovr_next;
            store_d_reg <= store;
            irq_reg     <= irq_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= entry;
                end
            end
        end
    end

endmodule
